// File: rtl/life_scan_ctl_if.sv
// Scan-controller bus for the Life LED matrix: enable/swap inputs, scan index and frame status outputs.
// Ports: enable, swap_req (to controller); cnt {row,col}, blank, frame_done, swap_ack, buf_sel (from controller).
// master = scan controller side, slave = display/engine side.
interface life_scan_ctl_if #(
   parameter int LOG2X = 3,
   parameter int LOG2Y = 3
);
   logic                   enable;
   logic                   swap_req;
   logic [LOG2X+LOG2Y-1:0] cnt;
   logic                   blank;
   logic                   frame_done;
   logic                   swap_ack;
   logic                   buf_sel;

   modport master (
      input  enable, swap_req,
      output cnt, blank, frame_done, swap_ack, buf_sel
   );

   modport slave (
      output enable, swap_req,
      input  cnt, blank, frame_done, swap_ack, buf_sel
   );
endinterface

// File: rtl/life_scan_ctl.sv
// Scan sequencer: steps the {row,col} cell index at a prescaled rate, blanks at row changes,
// and applies frame-buffer swaps only at frame boundaries. All outputs registered (1-cycle latency).
// No backpressure: enable=0 parks the scan in IDLE (blanked, cnt=0) while keeping a pending swap.
// Ports: clk, reset (async, active-low), bus (life_scan_ctl_if.master).
// Build option LIFE_SCAN_BLANK_EN: when defined, BLANK_CYC blanking cycles follow each row change.
module life_scan_ctl #(
   parameter int X         = 8,
   parameter int Y         = 8,
   parameter int LOG2X     = 3,
   parameter int LOG2Y     = 3,
   parameter int PRESCALE  = 16,
   parameter int BLANK_CYC = 2
) (
   input logic              clk,
   input logic              reset,
   life_scan_ctl_if.master  bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [LOG2Y-1:0] COL_LAST = LOG2Y'(Y - 1);
   localparam logic [LOG2X-1:0] ROW_LAST = LOG2X'(X - 1);

`ifdef LIFE_SCAN_BLANK_EN
   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_CYC - 1);
   typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
   logic [BW-1:0] blk_cnt, blk_cnt_nx;
`else
   typedef enum logic {IDLE, SCAN} state_t;
`endif

   state_t            state, state_nx;
   logic [LOG2X-1:0]  row, row_nx;
   logic [LOG2Y-1:0]  col, col_nx;
   logic [PW-1:0]     presc, presc_nx;
   logic              blank, blank_nx;
   logic              frame_done, frame_done_nx;
   logic              swap_ack, swap_ack_nx;
   logic              buf_sel, buf_sel_nx;
   logic              pend, pend_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         presc      <= '0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
         swap_ack   <= 1'b0;
         buf_sel    <= 1'b0;
         pend       <= 1'b0;
`ifdef LIFE_SCAN_BLANK_EN
         blk_cnt    <= '0;
`endif
      end else begin
         state      <= state_nx;
         row        <= row_nx;
         col        <= col_nx;
         presc      <= presc_nx;
         blank      <= blank_nx;
         frame_done <= frame_done_nx;
         swap_ack   <= swap_ack_nx;
         buf_sel    <= buf_sel_nx;
         pend       <= pend_nx;
`ifdef LIFE_SCAN_BLANK_EN
         blk_cnt    <= blk_cnt_nx;
`endif
      end
   end

   always_comb begin
      state_nx      = state;
      row_nx        = row;
      col_nx        = col;
      presc_nx      = presc;
      blank_nx      = blank;
      frame_done_nx = 1'b0;
      swap_ack_nx   = 1'b0;
      buf_sel_nx    = buf_sel;
      // A request is remembered whatever the scan is doing; only a frame end consumes it.
      pend_nx       = pend | bus.swap_req;
`ifdef LIFE_SCAN_BLANK_EN
      blk_cnt_nx    = blk_cnt;
`endif
      if (!bus.enable) begin
         // Disable wins over any tick in the same cycle: no frame_done, no swap.
         state_nx = IDLE;
         row_nx   = '0;
         col_nx   = '0;
         presc_nx = '0;
         blank_nx = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SCAN;
               row_nx   = '0;
               col_nx   = '0;
               presc_nx = '0;
               blank_nx = 1'b0;
            end
            SCAN: begin
               if (presc == PRE_LAST) begin
                  presc_nx = '0;
                  if (col != COL_LAST) begin
                     col_nx = col + LOG2Y'(1);
                  end else begin
                     col_nx = '0;
                     row_nx = (row == ROW_LAST) ? '0 : row + LOG2X'(1);
`ifdef LIFE_SCAN_BLANK_EN
                     state_nx   = BLANK;
                     blank_nx   = 1'b1;
                     blk_cnt_nx = '0;
`endif
                     if (row == ROW_LAST) begin
                        frame_done_nx = 1'b1;
                        // A request arriving on the frame-end tick itself still makes this frame.
                        if (pend || bus.swap_req) begin
                           buf_sel_nx  = ~buf_sel;
                           swap_ack_nx = 1'b1;
                           pend_nx     = 1'b0;
                        end
                     end
                  end
               end else begin
                  presc_nx = presc + PW'(1);
               end
            end
`ifdef LIFE_SCAN_BLANK_EN
            BLANK: begin
               if (blk_cnt == BLK_LAST) begin
                  state_nx = SCAN;
                  blank_nx = 1'b0;
                  presc_nx = '0;
               end else begin
                  blk_cnt_nx = blk_cnt + BW'(1);
               end
            end
`endif
            default: state_nx = IDLE;
         endcase
      end
   end

   assign bus.cnt        = {row, col};
   assign bus.blank      = blank;
   assign bus.frame_done = frame_done;
   assign bus.swap_ack   = swap_ack;
   assign bus.buf_sel    = buf_sel;

endmodule

// File: tb/tb_life_scan_ctl.sv
// Testbench for life_scan_ctl: random and targeted enable/swap/reset stimulus, with a
// time-based reference model feeding a scoreboard queue that a negedge monitor drains.
// Ports: none (instantiates life_scan_ctl_if and life_scan_ctl, clk period 10).
module tb_life_scan_ctl;
   localparam int X = 8, Y = 8, LOG2X = 3, LOG2Y = 3, P = 4, B_CYC = 2;
`ifdef LIFE_SCAN_BLANK_EN
   localparam int B = B_CYC;
`else
   localparam int B = 0;
`endif
   localparam int ROWP  = Y * P + B;
   localparam int FRAME = X * ROWP;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   life_scan_ctl_if #(.LOG2X(LOG2X), .LOG2Y(LOG2Y)) bus ();

   life_scan_ctl #(
      .X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y), .PRESCALE(P), .BLANK_CYC(B_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LOG2X+LOG2Y-1:0] cnt;
      logic                   blank;
      logic                   fd;
      logic                   ack;
      logic                   bsel;
   } obs_t;

   obs_t q[$];
   obs_t last_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_cyc    = 0;

   // Reference model: position in the scan is a pure function of cycles since enable.
   bit m_active = 0;
   int m_t      = 0;
   bit m_pend   = 0;
   bit m_buf    = 0;

   function automatic obs_t view(bit active, int t, bit fd, bit ack, bit bsel);
      obs_t e;
      int   u, row, o, col;
      e.fd   = fd;
      e.ack  = ack;
      e.bsel = bsel;
      if (!active) begin
         e.cnt   = '0;
         e.blank = 1'b1;
      end else begin
         // Shift by B so the frame looks like X identical rows of (blank, scan).
         u   = (t + B) % FRAME;
         row = u / ROWP;
         o   = u % ROWP;
         if (o < B) begin
            col     = 0;
            e.blank = 1'b1;
         end else begin
            col     = (o - B) / P;
            e.blank = 1'b0;
         end
         e.cnt = (LOG2X+LOG2Y)'(row * (1 << LOG2Y) + col);
      end
      return e;
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit req, output obs_t e);
      bit fd, ack;
      fd  = 0;
      ack = 0;
      if (!rst) begin
         m_active = 0; m_t = 0; m_pend = 0; m_buf = 0;
      end else if (!en) begin
         m_active = 0; m_t = 0; m_pend = m_pend | req;
      end else begin
         if (!m_active) begin
            m_active = 1; m_t = 0;
         end else begin
            m_t++;
         end
         fd = (m_t > 0) && ((m_t + B) % FRAME == 0);
         if (fd && (m_pend || req)) begin
            m_buf  = ~m_buf;
            ack    = 1;
            m_pend = 0;
         end else begin
            m_pend = m_pend | req;
         end
      end
      e = view(m_active, m_t, fd, ack, m_buf);
   endtask

   // True when the coming edge is the frame-end tick (assuming enable stays high).
   function automatic bit tick_next();
      return m_active && ((m_t + 1 + B) % FRAME == 0);
   endfunction

   task automatic cycle(input bit rst, input bit en, input bit req);
      obs_t e;
      bit   flush;
      @(posedge clk);
      #1;
      flush = (reset == 1'b1) && (rst == 1'b0);
      reset        = rst;
      bus.enable   = en;
      bus.swap_req = req;
      model_step(rst, en, req, e);
      if (flush) begin
         // Async reset: the outputs already visible this cycle must be the reset values.
         q.delete();
         q.push_back(e);
      end
      q.push_back(e);
      last_e = e;
      n_cyc++;
   endtask

   task automatic run(input int n, input int req_odds);
      for (int i = 0; i < n; i++)
         cycle(1, 1, (req_odds > 0) && ($urandom_range(0, req_odds - 1) == 0));
   endtask

   task automatic run_to_tick();
      int k;
      k = 0;
      while (!tick_next() && k < FRAME + 10) begin
         cycle(1, 1, 0);
         k++;
      end
   endtask

   task automatic run_to_cnt(input int c);
      int k;
      k = 0;
      while (int'(last_e.cnt) != c && k < FRAME + 10) begin
         cycle(1, 1, 0);
         k++;
      end
   endtask

   // Monitor: one scoreboard entry per cycle, compared away from the active edge.
   initial begin
      obs_t e, got;
      forever begin
         @(negedge clk);
         got = {bus.cnt, bus.blank, bus.frame_done, bus.swap_ack, bus.buf_sel};
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t got cnt=%0d", $time, got.cnt);
         end else begin
            e = q.pop_front();
            if (got !== e)
               begin
                  n_fail++;
                  $display("FAIL scan_out t=%0t got cnt=%0d blank=%b fd=%b ack=%b bsel=%b, expected cnt=%0d blank=%b fd=%b ack=%b bsel=%b",
                           $time, got.cnt, got.blank, got.fd, got.ack, got.bsel,
                           e.cnt, e.blank, e.fd, e.ack, e.bsel);
               end
         end
      end
   end

   initial begin
      obs_t e0;
      bus.enable   = 1'b0;
      bus.swap_req = 1'b0;
      model_step(0, 0, 0, e0);
      q.push_back(e0);
      last_e = e0;

      // Held in reset with enable high and swap requests: everything stays reset.
      for (int i = 0; i < 6; i++) cycle(0, 1, 1'($urandom_range(0, 1)));
      // Released with enable low: still idle.
      for (int i = 0; i < 4; i++) cycle(1, 0, 0);

      // Free-running scan with sparse random swap requests.
      run(2 * FRAME + 50, 150);

      // Two requests inside one frame (cnt 10 and 40) give a single swap.
      run_to_tick();
      cycle(1, 1, 0);
      run_to_cnt(10);
      cycle(1, 1, 1);
      run_to_cnt(40);
      cycle(1, 1, 1);
      run_to_tick();
      run(20, 0);

      // Request on the frame-end tick itself, then one in the cycle after a tick.
      run_to_tick();
      cycle(1, 1, 1);
      run(10, 0);
      run_to_tick();
      cycle(1, 1, 0);
      cycle(1, 1, 1);
      run(FRAME + 10, 0);

      // Disable at cnt 20 with a swap pending; re-enable and let it apply.
      run_to_cnt(5);
      cycle(1, 1, 1);
      run_to_cnt(20);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      run(FRAME + 20, 0);

      // Reset at cnt 30 with a swap pending discards it.
      run_to_cnt(5);
      cycle(1, 1, 1);
      run_to_cnt(30);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0);
      cycle(1, 0, 0);
      run(FRAME + 20, 0);

      // Mixed random enable drops and swap requests.
      for (int i = 0; i < 1500; i++)
         cycle(1, $urandom_range(0, 149) != 0, $urandom_range(0, 59) == 0);

      repeat (2) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
